// File: rtl/gate_bist_checker.sv
// -----------------------------------------------------------------------------
// gate_bist_checker
//
// Built-in self test sequencer for a small combinational gate under test (GUT).
// On an accepted start it walks vec_out through every input combination
// 0 .. 2**N_IN-1, holds each one for SETTLE_CYCLES clocks, samples dut_y on the
// last clock of the hold and compares it with TRUTH_TABLE[vec_out]. It reports
// the number of mismatching vectors, the lowest mismatching vector and an
// overall pass flag once the sweep completes.
//
// Parameters:
//   N_IN          number of GUT inputs (1..4)
//   TRUTH_TABLE   bit k = expected dut_y for input vector k (default: 2-in AND)
//   SETTLE_CYCLES clocks each vector is held before dut_y is sampled (>= 1)
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            begin a run; honoured only in IDLE or DONE
//   vec_out          stimulus to the GUT inputs, bit 0 = LSB input
//   dut_y            GUT output, synchronous input
//   busy             high while a run is in progress
//   done             high from run completion until the next accepted start
//   pass             high with done when no vector mismatched
//   err_count        number of mismatching vectors in the current/last run
//   first_fail_vec   lowest vector that mismatched
//   first_fail_valid high once any mismatch has been recorded in this run
// -----------------------------------------------------------------------------
module gate_bist_checker #(
  parameter int                 N_IN          = 2,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE   = 4'b1000,
  parameter int                 SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int NVEC = 1 << N_IN;
  // Counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_MAX    = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_MAX    = (N_IN + 1)'(NVEC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic            mismatch;

  assign mismatch = (dut_y != TRUTH_TABLE[vec_q]);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          vec_d     = '0;
          cnt_d     = CNT_RELOAD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Sample edge: score the vector currently on vec_out.
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + (N_IN + 1)'(1);
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q != VEC_MAX) begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = CNT_RELOAD;
          end else begin
            // Last vector: vec_out stays put; pass must include this sample.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == '0) && !mismatch;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_checker
//
// Two checker instances: u_dut0 (defaults, SETTLE_CYCLES=1) and u_dut1
// (SETTLE_CYCLES=3). Each GUT is modelled as a 4-entry lookup table indexed by
// vec_out, so any 2-input gate (or fault) can be swapped in at run time.
// Expected results come from hand-derived vectors and from a run-level model
// that compares the GUT table against the expected table bit by bit.
// -----------------------------------------------------------------------------
module tb_gate_bist_checker;

  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;

  logic       clk;
  logic       rst_n;

  logic       start0, start1;
  logic [1:0] vec0, vec1;
  logic       y0, y1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  logic [1:0] ffv0, ffv1;
  logic       ffval0, ffval1;

  logic [3:0] gut0, gut1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Combinational GUTs driven from the checker stimulus.
  assign y0 = gut0[vec0];
  assign y1 = gut1[vec1];

  gate_bist_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run-level reference: a vector fails when the GUT disagrees with the
  // expected table; results follow directly from the set of failing vectors.
  task automatic model(input logic [3:0] gut, input logic [3:0] tt,
                       output int err, output logic [1:0] ffv,
                       output logic ffvalid, output logic pass);
    logic [3:0] diff;
    diff    = gut ^ tt;
    err     = 0;
    ffv     = 2'd0;
    ffvalid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (diff[v]) begin
        err++;
        if (!ffvalid) begin
          ffv     = 2'(v);
          ffvalid = 1'b1;
        end
      end
    end
    pass = (diff == 4'b0000);
  endtask

  // Full run on u_dut0: pulse start, follow the sweep, check latency and
  // final results.
  task automatic run0(input logic [3:0] gut, input int exp_err, input logic [1:0] exp_ffv,
                      input logic exp_ffvalid, input logic exp_pass, input string name);
    int k;
    int vec_bad;
    gut0 = gut;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    vec_bad = 0;
    check({name, " busy after accept"}, 32'(busy0), 32'd1);
    while (!done0 && k < 64) begin
      if (vec0 !== 2'(k)) vec_bad++;
      @(negedge clk);
      k++;
    end
    check({name, " vec_out steps"}, 32'(vec_bad), 32'd0);
    check({name, " done"}, 32'(done0), 32'd1);
    check({name, " latency"}, 32'(k), 32'd4);
    check({name, " busy"}, 32'(busy0), 32'd0);
    check({name, " vec_out held"}, 32'(vec0), 32'd3);
    check({name, " err_count"}, 32'(err0), 32'(exp_err));
    check({name, " first_fail_valid"}, 32'(ffval0), 32'(exp_ffvalid));
    check({name, " first_fail_vec"}, 32'(ffv0), 32'(exp_ffv));
    check({name, " pass"}, 32'(pass0), 32'(exp_pass));
  endtask

  typedef struct {
    logic [3:0] gut;
    int         err;
    logic [1:0] ffv;
    logic       ffvalid;
    logic       pass;
    string      name;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int         k;
    int         e;
    logic [1:0] fv;
    logic       fval;
    logic       p;
    logic [3:0] g;

    tbl[0] = '{4'b1000, 0, 2'd0, 1'b0, 1'b1, "and"};
    tbl[1] = '{4'b0000, 1, 2'd3, 1'b1, 1'b0, "stuck0"};
    tbl[2] = '{4'b1110, 2, 2'd1, 1'b1, 1'b0, "or"};
    tbl[3] = '{4'b0110, 3, 2'd1, 1'b1, 1'b0, "xor"};
    tbl[4] = '{4'b0111, 4, 2'd0, 1'b1, 1'b0, "nand"};
    tbl[5] = '{4'b1111, 3, 2'd0, 1'b1, 1'b0, "stuck1"};

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    gut0   = TT_AND;
    gut1   = TT_AND;

    // Reset state
    #12;
    check("rst vec_out", 32'(vec0), 32'd0);
    check("rst busy", 32'(busy0), 32'd0);
    check("rst done", 32'(done0), 32'd0);
    check("rst pass", 32'(pass0), 32'd0);
    check("rst err_count", 32'(err0), 32'd0);
    check("rst first_fail_vec", 32'(ffv0), 32'd0);
    check("rst first_fail_valid", 32'(ffval0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no start", 32'(busy0), 32'd0);

    // Table-driven gates
    foreach (tbl[i])
      run0(tbl[i].gut, tbl[i].err, tbl[i].ffv, tbl[i].ffvalid, tbl[i].pass, tbl[i].name);

    // Back-to-back: OR run ends in DONE, swap to AND and restart from DONE.
    run0(TT_OR, 2, 2'd1, 1'b1, 1'b0, "b2b or");
    gut0 = TT_AND;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("b2b accept done", 32'(done0), 32'd0);
    check("b2b accept pass", 32'(pass0), 32'd0);
    check("b2b accept err_count", 32'(err0), 32'd0);
    check("b2b accept ffvalid", 32'(ffval0), 32'd0);
    check("b2b accept vec_out", 32'(vec0), 32'd0);
    k = 0;
    while (!done0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("b2b second latency", 32'(k), 32'd4);
    check("b2b second pass", 32'(pass0), 32'd1);
    check("b2b second err_count", 32'(err0), 32'd0);

    // SETTLE_CYCLES=3 with a start re-pulse at clock 5 of the run
    gut1 = TT_AND;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    e = 0;
    while (!done1 && k < 100) begin
      if (vec1 !== 2'(k / 3)) e++;
      if (k == 4) start1 = 1'b1;
      if (k == 5) start1 = 1'b0;
      @(negedge clk);
      k++;
    end
    check("settle3 vec_out hold", 32'(e), 32'd0);
    check("settle3 latency", 32'(k), 32'd12);
    check("settle3 pass", 32'(pass1), 32'd1);
    check("settle3 err_count", 32'(err1), 32'd0);
    check("settle3 vec_out last", 32'(vec1), 32'd3);

    // Reset mid-run at vector 2 of an OR run
    gut0 = TT_OR;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (vec0 !== 2'd2 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("midrst reached vec 2", 32'(vec0), 32'd2);
    check("midrst ffvalid before", 32'(ffval0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst vec_out", 32'(vec0), 32'd0);
    check("midrst busy", 32'(busy0), 32'd0);
    check("midrst done", 32'(done0), 32'd0);
    check("midrst pass", 32'(pass0), 32'd0);
    check("midrst err_count", 32'(err0), 32'd0);
    check("midrst first_fail_vec", 32'(ffv0), 32'd0);
    check("midrst first_fail_valid", 32'(ffval0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run0(TT_AND, 0, 2'd0, 1'b0, 1'b1, "after rst and");

    // Randomized GUT tables against the run-level model
    for (int i = 0; i < 20; i++) begin
      g = 4'($urandom_range(0, 15));
      model(g, TT_AND, e, fv, fval, p);
      run0(g, e, fv, fval, p, $sformatf("rand %0d gut=%b", i, g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Self-checking sequencer that drives every input combination into a small combinational gate under test (GUT), samples the gate's output, and compares it against an expected truth table.
- Reports pass/fail, an error count, and the first failing vector.
- Sits beside any 2..4-input gate as an in-fabric built-in self test, so gate verification runs in hardware with no simulator display.

Parameters:
- N_IN, 2, number of GUT inputs (legal 1..4); vectors run 0 to 2**N_IN-1.
- TRUTH_TABLE, 4'b1000, expected output per vector; bit k = expected y for input vector k. Width 2**N_IN. Default is 2-input AND.
- SETTLE_CYCLES, 1, clocks each vector is held before dut_y is sampled (legal >=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; honoured only in IDLE or DONE.
- vec_out  output  N_IN  stimulus to GUT inputs; vec_out[0] = LSB input.
- dut_y  input  1  GUT output, sampled synchronously.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start.
- pass  output  1  high with done when err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors in the last run (saturates at 2**N_IN, cannot overflow).
- first_fail_vec  output  N_IN  lowest vector that mismatched.
- first_fail_valid  output  1  high once any mismatch has been recorded in the current run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, settle counter=0. Deassertion takes effect at the next rising edge.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at an edge:
  - vec_out<=0, settle counter<=SETTLE_CYCLES-1, state<=RUN, busy<=1.
  - done<=0, pass<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0.
- RUN, counter != 0: decrement the counter; vec_out is held.
- RUN, counter == 0 (sample edge):
  - Compare dut_y with TRUTH_TABLE[vec_out].
  - On mismatch: err_count<=err_count+1; if first_fail_valid==0, first_fail_vec<=vec_out and first_fail_valid<=1.
- RUN, sample edge, vec_out != 2**N_IN-1: vec_out<=vec_out+1, counter reloads to SETTLE_CYCLES-1.
- RUN, sample edge, vec_out == 2**N_IN-1 (last vector):
  - state<=DONE, busy<=0, done<=1.
  - pass<=1 iff no mismatch in the whole run, including this last sample.
  - vec_out stays at the last vector (no wrap to 0).
- Timing: each vector is held exactly SETTLE_CYCLES clocks. done rises 2**N_IN*SETTLE_CYCLES clocks after the start-accept edge (default: 4 clocks).
- start while in RUN: ignored; the run is not restarted.
- start held high continuously: a new run begins on every edge spent in DONE. Level start is legal; the bench should pulse it.
- Reset mid-run: all state is cleared immediately and the partial results are lost.
- dut_y is treated as a synchronous input. The GUT is combinational from vec_out; no resynchroniser is inside this block.
- err_count, first_fail_* and pass are stable and valid whenever done=1. They update incrementally during RUN.

Test Plan:
- Correct AND GUT (y=a&b), start pulse 1 clock:
  - vec_out steps 0,1,2,3 on consecutive clocks.
  - done=1 and pass=1 four clocks after start; err_count=0, first_fail_valid=0.
- GUT stuck-at-0 (dut_y=0):
  - err_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0, done=1.
- GUT = OR gate:
  - Mismatches on vectors 01 and 10.
  - err_count=2, first_fail_vec=2'b01, pass=0.
- SETTLE_CYCLES=3, correct AND GUT:
  - Each vec_out value is held 3 clocks; done rises 12 clocks after start; pass=1.
  - Re-pulsing start during RUN at clock 5 changes nothing.
- Reset mid-run: assert rst_n=0 asynchronously at vector 2 of an OR-GUT run.
  - All outputs are immediately 0 and state is IDLE.
  - A fresh start with a correct AND GUT gives pass=1, err_count=0.
- Back-to-back runs: OR-GUT run ends (pass=0, err_count=2); swap to AND GUT; start in DONE.
  - done and pass clear on the accept edge, err_count resets to 0.
  - Second run ends with pass=1.
